// File: rtl/bcd_multi_counter.sv
// bcd_multi_counter: cascaded multi-digit BCD up/down counter on one clock.
// Digit 0 is least significant and occupies bits [3:0].
// Supports synchronous clear, parallel load (nibbles above 9 saturate to 9),
// registered per-digit wrap strobes and terminal carry/borrow strobes.
// Optional lap-hold display register is compiled in with `define BCD_LAP_EN.
module bcd_multi_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   disp,
    output logic [DIGITS-1:0]     digit_wrap,
    output logic                  carry,
    output logic                  borrow,
    output logic                  frozen
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]      count_q, count_d;
    logic [DIGITS-1:0] wrap_q, wrap_d;
    logic              carry_q, carry_d;
    logic              borrow_q, borrow_d;

    // Next count and strobes: clr > load > en; each digit steps only when all
    // lower digits are at the rollover value for the current direction.
    always_comb begin
        logic       below_all9;
        logic       below_all0;
        logic [3:0] dig;
        count_d    = count_q;
        wrap_d     = '0;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        below_all9 = 1'b1;
        below_all0 = 1'b1;
        dig        = 4'd0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                dig = load_val[4*k +: 4];
                count_d[4*k +: 4] = (dig > 4'd9) ? 4'd9 : dig;
            end
        end else if (en) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                dig = count_q[4*k +: 4];
                if (up_dn) begin
                    if (below_all9) begin
                        if (dig == 4'd9) begin
                            count_d[4*k +: 4] = 4'd0;
                            wrap_d[k]         = 1'b1;
                        end else begin
                            count_d[4*k +: 4] = dig + 4'd1;
                        end
                    end
                end else begin
                    if (below_all0) begin
                        if (dig == 4'd0) begin
                            count_d[4*k +: 4] = 4'd9;
                            wrap_d[k]         = 1'b1;
                        end else begin
                            count_d[4*k +: 4] = dig - 4'd1;
                        end
                    end
                end
                below_all9 = below_all9 & (dig == 4'd9);
                below_all0 = below_all0 & (dig == 4'd0);
            end
            // After the loop these flags cover every digit: terminal wrap.
            carry_d  = up_dn & below_all9;
            borrow_d = ~up_dn & below_all0;
        end
    end

    // Count and strobe registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= '0;
            wrap_q   <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign count      = count_q;
    assign digit_wrap = wrap_q;
    assign carry      = carry_q;
    assign borrow     = borrow_q;

`ifdef BCD_LAP_EN
    logic [W-1:0] disp_q, disp_d;
    logic         frozen_q, frozen_d;

    // Lap toggles the hold; while not frozen disp follows the next count so
    // it matches count every cycle. clr releases the hold and zeroes disp.
    always_comb begin
        disp_d   = disp_q;
        frozen_d = frozen_q;
        if (clr) begin
            disp_d   = '0;
            frozen_d = 1'b0;
        end else begin
            if (lap) begin
                frozen_d = ~frozen_q;
            end
            if (lap || !frozen_q) begin
                disp_d = count_d;
            end
        end
    end

    // Lap-hold registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            disp_q   <= '0;
            frozen_q <= 1'b0;
        end else begin
            disp_q   <= disp_d;
            frozen_q <= frozen_d;
        end
    end

    assign disp   = disp_q;
    assign frozen = frozen_q;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign disp       = count_q;
    assign frozen     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Scoreboard bench for bcd_multi_counter (DIGITS=4). Each stimulus cycle
// pushes its hand-computed expectation tagged with the cycle it appears on;
// a negedge monitor pops and compares. Lap expectations apply when
// BCD_LAP_EN is defined; otherwise disp must equal count and frozen stay 0.
module tb_bcd_multi_counter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        lap = 1'b0;
    logic [15:0] count;
    logic [15:0] disp;
    logic [3:0]  digit_wrap;
    logic        carry;
    logic        borrow;
    logic        frozen;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [15:0] count;
        logic [15:0] disp;
        logic [3:0]  wrap;
        logic        carry;
        logic        borrow;
        logic        frozen;
    } exp_t;

    exp_t sb[$];

    bcd_multi_counter #(.DIGITS(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .up_dn      (up_dn),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .lap        (lap),
        .count      (count),
        .disp       (disp),
        .digit_wrap (digit_wrap),
        .carry      (carry),
        .borrow     (borrow),
        .frozen     (frozen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input string field,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: compare every expectation due on this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.name, "count", count, e.count);
            check(e.name, "disp", disp, e.disp);
            check(e.name, "digit_wrap", {12'd0, digit_wrap}, {12'd0, e.wrap});
            check(e.name, "carry", {15'd0, carry}, {15'd0, e.carry});
            check(e.name, "borrow", {15'd0, borrow}, {15'd0, e.borrow});
            check(e.name, "frozen", {15'd0, frozen}, {15'd0, e.frozen});
        end
    end

    // Drive one cycle of inputs and queue the result expected after the edge.
    task automatic apply(input string name, input logic rn, input logic en_v,
                         input logic up_v, input logic clr_v, input logic ld_v,
                         input logic [15:0] lv, input logic lap_v,
                         input logic [15:0] ec, input logic [15:0] ed,
                         input logic [3:0] ew, input logic ecar,
                         input logic ebor, input logic efr);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n  = rn;
        en       = en_v;
        up_dn    = up_v;
        clr      = clr_v;
        load     = ld_v;
        load_val = lv;
        lap      = lap_v;
        e.cyc    = cyc + 1;
        e.name   = name;
        e.count  = ec;
        e.wrap   = ew;
        e.carry  = ecar;
        e.borrow = ebor;
`ifdef BCD_LAP_EN
        e.disp   = ed;
        e.frozen = efr;
`else
        e.disp   = ec;
        e.frozen = 1'b0;
`endif
        sb.push_back(e);
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    initial begin
        //     name          rn en up cl ld load_val  lap count     disp      wrap     ca bo fr
        apply("reset",       0, 1, 1, 0, 1, 16'h1234, 0, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0);
        apply("load_0099",   1, 0, 1, 0, 1, 16'h0099, 0, 16'h0099, 16'h0099, 4'b0000, 0, 0, 0);
        apply("up_cascade",  1, 1, 1, 0, 0, 16'h0000, 0, 16'h0100, 16'h0100, 4'b0011, 0, 0, 0);
        apply("idle_clear",  1, 0, 1, 0, 0, 16'h0000, 0, 16'h0100, 16'h0100, 4'b0000, 0, 0, 0);
        apply("load_9999",   1, 0, 1, 0, 1, 16'h9999, 0, 16'h9999, 16'h9999, 4'b0000, 0, 0, 0);
        apply("carry_wrap",  1, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 4'b1111, 1, 0, 0);
        apply("borrow_wrap", 1, 1, 0, 0, 0, 16'h0000, 0, 16'h9999, 16'h9999, 4'b1111, 0, 1, 0);
        apply("down_plain",  1, 1, 0, 0, 0, 16'h0000, 0, 16'h9998, 16'h9998, 4'b0000, 0, 0, 0);
        apply("clr_prio",    1, 1, 1, 1, 1, 16'h5555, 0, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0);
        apply("load_sanit",  1, 0, 1, 0, 1, 16'hA3F1, 0, 16'h9391, 16'h9391, 4'b0000, 0, 0, 0);
        apply("down_9390",   1, 1, 0, 0, 0, 16'h0000, 0, 16'h9390, 16'h9390, 4'b0000, 0, 0, 0);
        apply("down_9389",   1, 1, 0, 0, 0, 16'h0000, 0, 16'h9389, 16'h9389, 4'b0001, 0, 0, 0);
        apply("dir_up_9390", 1, 1, 1, 0, 0, 16'h0000, 0, 16'h9390, 16'h9390, 4'b0001, 0, 0, 0);
        apply("load_prio",   1, 1, 1, 0, 1, 16'h0999, 0, 16'h0999, 16'h0999, 4'b0000, 0, 0, 0);
        apply("up_1000",     1, 1, 1, 0, 0, 16'h0000, 0, 16'h1000, 16'h1000, 4'b0111, 0, 0, 0);
        apply("load_9999b",  1, 0, 1, 0, 1, 16'h9999, 0, 16'h9999, 16'h9999, 4'b0000, 0, 0, 0);
        apply("mid_reset",   0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0);
        apply("load_0008",   1, 0, 1, 0, 1, 16'h0008, 0, 16'h0008, 16'h0008, 4'b0000, 0, 0, 0);
        apply("up_0009",     1, 1, 1, 0, 0, 16'h0000, 0, 16'h0009, 16'h0009, 4'b0000, 0, 0, 0);
        apply("up_0010",     1, 1, 1, 0, 0, 16'h0000, 0, 16'h0010, 16'h0010, 4'b0001, 0, 0, 0);
        apply("down_0009",   1, 1, 0, 0, 0, 16'h0000, 0, 16'h0009, 16'h0009, 4'b0001, 0, 0, 0);
        apply("up_0010b",    1, 1, 1, 0, 0, 16'h0000, 0, 16'h0010, 16'h0010, 4'b0001, 0, 0, 0);
        apply("clr",         1, 0, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0);
        // Lap sequence
        for (int n = 1; n <= 5; n++) begin
            apply("run5", 1, 1, 1, 0, 0, 16'h0000, 0, to_bcd(n), to_bcd(n), 4'b0000, 0, 0, 0);
        end
        apply("lap_freeze",  1, 1, 1, 0, 0, 16'h0000, 1, 16'h0006, 16'h0006, 4'b0000, 0, 0, 1);
        for (int n = 7; n <= 16; n++) begin
            apply("run_frozen", 1, 1, 1, 0, 0, 16'h0000, 0, to_bcd(n), 16'h0006,
                  (n % 10 == 0) ? 4'b0001 : 4'b0000, 0, 0, 1);
        end
        apply("lap_release", 1, 0, 1, 0, 0, 16'h0000, 1, 16'h0016, 16'h0016, 4'b0000, 0, 0, 0);
        apply("track_0017",  1, 1, 1, 0, 0, 16'h0000, 0, 16'h0017, 16'h0017, 4'b0000, 0, 0, 0);
        apply("lap_again",   1, 0, 1, 0, 0, 16'h0000, 1, 16'h0017, 16'h0017, 4'b0000, 0, 0, 1);
        apply("load_frozen", 1, 0, 1, 0, 1, 16'h0123, 0, 16'h0123, 16'h0017, 4'b0000, 0, 0, 1);
        apply("up_frozen",   1, 1, 1, 0, 0, 16'h0000, 0, 16'h0124, 16'h0017, 4'b0000, 0, 0, 1);
        apply("clr_unfreeze",1, 0, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0);

        @(posedge clk);
        #1;
        en   = 1'b0;
        clr  = 1'b0;
        load = 1'b0;
        lap  = 1'b0;
        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
